multiport_memory_controller: RTL and testbench

MULTIPORT_MEMORY_CONTROLLER -- requirements
Module: multiport_memory_controller

---
 rtl/multiport_memory_controller.sv | 184 ++++++++++++++++++
 tb/tb_multiport_memory_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_memory_controller.sv
// Round-robin multiport front end for an SDRAM driver: serialises port
// requests into single read/write commands and inserts periodic refreshes.
module multiport_memory_controller #(
    parameter int FREQ       = 54_000_000,
    parameter int NPORTS     = 2,
    parameter int AW         = 22,
    parameter int DW         = 16,
    parameter int OP_CYCLES  = 4,
    parameter int REFRESH_NS = 15625
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NPORTS-1:0]      p_read,
    input  logic [NPORTS-1:0]      p_write,
    input  logic [NPORTS*AW-1:0]   p_addr,
    input  logic [NPORTS*DW-1:0]   p_din,
    input  logic [NPORTS*DW/8-1:0] p_wdm,
    output logic [NPORTS-1:0]      p_ack,
    output logic [NPORTS-1:0]      p_rvalid,
    output logic [DW-1:0]          rdata,
    output logic                   ready,
    output logic                   fail,
    output logic [19:0]            total_written,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic                   mem_refresh,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_din,
    output logic [DW/8-1:0]        mem_wdm,
    input  logic                   mem_busy,
    input  logic [DW-1:0]          mem_dout,
    input  logic                   mem_data_ready
);

    // Refresh period in clk cycles, shortened by two ops so a refresh that
    // waits behind an in-flight op still meets the interval.
    localparam int RCYC = FREQ / 1_000_000 * REFRESH_NS / 1000 - 2 * OP_CYCLES;
    localparam int TW   = $clog2(RCYC + 1);
    localparam int CW   = $clog2(OP_CYCLES + 1);
    localparam int PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int BW   = DW / 8;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_OP, S_REFRESH} state_t;

    state_t          state;
    logic [CW-1:0]   op_cnt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   cur_port;
    logic            cur_read;
    logic [TW-1:0]   refresh_timer;
    logic            refresh_pending;
    logic            timer_hit;

    logic [NPORTS-1:0] req;
    logic              gnt_valid;
    logic [PW-1:0]     gnt_idx;
    logic [PW:0]       arb_idx;

    assign timer_hit = (state != S_INIT) && (refresh_timer == TW'(RCYC));

    // Round-robin search: first requesting port at or after rr_ptr.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        req       = p_read | p_write;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        arb_idx   = '0;
        for (int off = 0; off < NPORTS; off++) begin
            arb_idx = {1'b0, rr_ptr} + (PW+1)'(off);
            if (arb_idx >= (PW+1)'(NPORTS))
                arb_idx = arb_idx - (PW+1)'(NPORTS);
            if (!gnt_valid && req[arb_idx[PW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = arb_idx[PW-1:0];
            end
        end
    end

    // Free-running refresh interval timer, held at zero until init completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            refresh_timer <= '0;
        else if (state == S_INIT || timer_hit)
            refresh_timer <= '0;
        else
            refresh_timer <= refresh_timer + TW'(1);
    end

    // Main controller FSM with registered strobes, acks and status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= S_INIT;
            op_cnt          <= '0;
            rr_ptr          <= '0;
            cur_port        <= '0;
            cur_read        <= 1'b0;
            refresh_pending <= 1'b0;
            p_ack           <= '0;
            p_rvalid        <= '0;
            rdata           <= '0;
            ready           <= 1'b0;
            fail            <= 1'b0;
            total_written   <= '0;
            mem_rd          <= 1'b0;
            mem_wr          <= 1'b0;
            mem_refresh     <= 1'b0;
            mem_addr        <= '0;
            mem_din         <= '0;
            mem_wdm         <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            p_ack       <= '0;
            p_rvalid    <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_refresh <= 1'b0;
            if (timer_hit)
                refresh_pending <= 1'b1;

            unique case (state)
                S_INIT: begin
                    if (!mem_busy) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (refresh_pending) begin
                        mem_refresh     <= 1'b1;
                        refresh_pending <= timer_hit;
                        state           <= S_REFRESH;
                        op_cnt          <= CW'(1);
                        ready           <= 1'b0;
                    end else if (gnt_valid) begin
                        p_ack[gnt_idx] <= 1'b1;
                        // A port asserting both read and write is served as a write.
                        if (p_write[gnt_idx]) begin
                            mem_wr        <= 1'b1;
                            cur_read      <= 1'b0;
                            total_written <= total_written + 20'd1;
                        end else begin
                            mem_rd   <= 1'b1;
                            cur_read <= 1'b1;
                        end
                        mem_addr <= p_addr[int'(gnt_idx)*AW +: AW];
                        mem_din  <= p_din[int'(gnt_idx)*DW +: DW];
                        mem_wdm  <= p_wdm[int'(gnt_idx)*BW +: BW];
                        cur_port <= gnt_idx;
                        rr_ptr   <= (gnt_idx == PW'(NPORTS-1)) ? '0 : gnt_idx + PW'(1);
                        state    <= S_OP;
                        op_cnt   <= CW'(1);
                        ready    <= 1'b0;
                    end else begin
                        ready <= !timer_hit;
                    end
                end
                S_OP: begin
                    if (op_cnt == CW'(OP_CYCLES)) begin
                        state <= S_IDLE;
                        ready <= !(refresh_pending || timer_hit);
                        if (cur_read) begin
                            rdata              <= mem_dout;
                            p_rvalid[cur_port] <= 1'b1;
                            if (!mem_data_ready)
                                fail <= 1'b1;
                        end
                    end else begin
                        op_cnt <= op_cnt + CW'(1);
                    end
                end
                S_REFRESH: begin
                    if (op_cnt == CW'(OP_CYCLES)) begin
                        state <= S_IDLE;
                        ready <= !(refresh_pending || timer_hit);
                    end else begin
                        op_cnt <= op_cnt + CW'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_multiport_memory_controller.sv
// Scoreboard bench: stimulus pushes expected commands per port, a negedge
// monitor checks arbitration, commands, read returns and refresh spacing
// against a word-level memory model and the round-robin rule.
module tb_multiport_memory_controller;

    localparam int FREQ       = 54_000_000;
    localparam int NPORTS     = 2;
    localparam int AW         = 22;
    localparam int DW         = 16;
    localparam int OP_CYCLES  = 4;
    localparam int REFRESH_NS = 15625;
    localparam int BW         = DW / 8;
    localparam int RCYC       = (FREQ / 1_000_000) * REFRESH_NS / 1000 - 2 * OP_CYCLES;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [NPORTS-1:0]      p_read, p_write;
    logic [NPORTS*AW-1:0]   p_addr;
    logic [NPORTS*DW-1:0]   p_din;
    logic [NPORTS*BW-1:0]   p_wdm;
    logic [NPORTS-1:0]      p_ack, p_rvalid;
    logic [DW-1:0]          rdata;
    logic                   ready, fail;
    logic [19:0]            total_written;
    logic                   mem_rd, mem_wr, mem_refresh;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_din;
    logic [BW-1:0]          mem_wdm;
    logic                   mem_busy;
    logic [DW-1:0]          mem_dout;
    logic                   mem_data_ready;

    multiport_memory_controller #(
        .FREQ(FREQ), .NPORTS(NPORTS), .AW(AW), .DW(DW),
        .OP_CYCLES(OP_CYCLES), .REFRESH_NS(REFRESH_NS)
    ) dut (
        .clk(clk), .resetn(resetn),
        .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_din(p_din), .p_wdm(p_wdm),
        .p_ack(p_ack), .p_rvalid(p_rvalid), .rdata(rdata), .ready(ready), .fail(fail),
        .total_written(total_written),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wdm(mem_wdm),
        .mem_busy(mem_busy), .mem_dout(mem_dout), .mem_data_ready(mem_data_ready)
    );

    always #5 clk = ~clk;

    typedef struct { bit rd; bit wr; logic [AW-1:0] addr; logic [DW-1:0] din; logic [BW-1:0] wdm; } cmd_t;
    typedef struct { int port; logic [DW-1:0] data; bit drop; int ack_cyc; } rsp_t;

    cmd_t exp_q [NPORTS][$];
    rsp_t rd_q [$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] sdram [int];
    logic [AW-1:0] addr_tbl [8] = '{22'h012345, 22'h000000, 22'h3FFFFF, 22'h2AAAAA,
                                   22'h155555, 22'h000100, 22'h3F0001, 22'h012346};

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  drop_ready = 1'b0;

    // monitor model state
    int  cyc = 0;
    int  m_ptr, op_left, ref_left, last_ref, ref_count, rd_strobes;
    int  model_written;
    bit  model_fail, seen_ready;
    logic [DW-1:0]     model_rdata;
    logic [NPORTS-1:0] prev_req = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                            input logic [BW-1:0] wdm);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++)
            if (!wdm[b]) r[b*8 +: 8] = din[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] sd_read(input logic [AW-1:0] a);
        return sdram.exists(int'(a)) ? sdram[int'(a)] : init_word(a);
    endfunction

    // SDRAM driver emulation: read data valid on the OP_CYCLES-th cycle of a read.
    int rd_cnt = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            rd_cnt = 0;
            mem_data_ready = 1'b0;
        end else begin
            if (mem_wr) sdram[int'(mem_addr)] = merge(sd_read(mem_addr), mem_din, mem_wdm);
            if (mem_rd) rd_cnt = 1;
            else if (rd_cnt != 0) rd_cnt = (rd_cnt == OP_CYCLES) ? 0 : rd_cnt + 1;
            if (rd_cnt == OP_CYCLES) begin
                mem_dout       = sd_read(mem_addr);
                mem_data_ready = !drop_ready;
            end else begin
                mem_dout       = DW'($urandom);
                mem_data_ready = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        cmd_t e;
        rsp_t r;
        int g, idx;
        bit found;
        logic [NPORTS-1:0] onehot;
        if (!resetn) begin
            m_ptr = 0; op_left = 0; ref_left = 0; model_written = 0; model_rdata = '0;
            model_fail = 0; seen_ready = 0; last_ref = 0;
            rd_q.delete();
            for (int p = 0; p < NPORTS; p++) exp_q[p].delete();
        end else begin
            cyc++;
            if (op_left > 0) op_left--;
            if (ref_left > 0) ref_left--;
            if (ready && !seen_ready) begin
                seen_ready = 1;
                last_ref   = cyc;
            end
            if ((p_ack | p_rvalid) != '0 || mem_rd || mem_wr || mem_refresh) begin
                check("ack_onehot", ($countones(p_ack) <= 1), 1);
                check("rvalid_onehot", ($countones(p_rvalid) <= 1), 1);
                check("strobe_exclusive", ($countones({mem_rd, mem_wr, mem_refresh}) <= 1), 1);
            end
            if (p_ack != '0) begin
                found = 0; g = 0;
                for (int off = 0; off < NPORTS; off++) begin
                    idx = (m_ptr + off) % NPORTS;
                    if (!found && prev_req[idx]) begin found = 1; g = idx; end
                end
                check("ack_has_req", found, 1);
                if (found) begin
                    onehot = '0; onehot[g] = 1'b1;
                    check("grant_port", p_ack, onehot);
                    check("ack_not_in_refresh", ref_left, 0);
                    m_ptr = (g + 1) % NPORTS;
                    check("ack_expected", exp_q[g].size(), 1);
                    if (exp_q[g].size() > 0) begin
                        e = exp_q[g].pop_front();
                        check("cmd_rd", mem_rd, e.rd);
                        check("cmd_wr", mem_wr, e.wr);
                        check("cmd_addr", mem_addr, e.addr);
                        if (e.wr) begin
                            check("cmd_din", mem_din, e.din);
                            check("cmd_wdm", mem_wdm, e.wdm);
                            check("rdata_hold_wr", rdata, model_rdata);
                            ref_mem[int'(e.addr)] = merge(ref_read(e.addr), e.din, e.wdm);
                            model_written++;
                            check("total_written", total_written, 20'(model_written));
                        end else begin
                            rd_strobes++;
                            r.port = g; r.data = ref_read(e.addr); r.drop = drop_ready; r.ack_cyc = cyc;
                            rd_q.push_back(r);
                        end
                    end
                    op_left = OP_CYCLES;
                end
            end else if (mem_rd || mem_wr) begin
                check("strobe_has_ack", 0, 1);
            end
            if (mem_refresh) begin
                check("refresh_not_in_op", op_left, 0);
                check("rdata_hold_ref", rdata, model_rdata);
                if (seen_ready)
                    check_range("refresh_interval", cyc - last_ref, RCYC - 2*OP_CYCLES, RCYC + 2*OP_CYCLES);
                last_ref = cyc;
                ref_count++;
                ref_left = OP_CYCLES;
            end
            if (p_rvalid != '0) begin
                check("rvalid_expected", (rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    r = rd_q.pop_front();
                    onehot = '0; onehot[r.port] = 1'b1;
                    check("rvalid_port", p_rvalid, onehot);
                    check("rvalid_latency", cyc - r.ack_cyc, OP_CYCLES);
                    check("rdata", rdata, r.data);
                    model_rdata = r.data;
                    if (r.drop) model_fail = 1;
                    check("fail_flag", fail, model_fail);
                end
            end
            if (op_left > 0 || ref_left > 0)
                check("ready_low_busy", ready, 0);
        end
        prev_req = p_read | p_write;
    end

    task automatic do_req(input int port, input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din, input logic [BW-1:0] wdm);
        cmd_t c;
        int k;
        @(posedge clk); #1;
        p_read[port]  = rd;
        p_write[port] = wr;
        p_addr[port*AW +: AW] = addr;
        p_din[port*DW +: DW]  = din;
        p_wdm[port*BW +: BW]  = wdm;
        c.rd = rd && !wr; c.wr = wr; c.addr = addr; c.din = din; c.wdm = wdm;
        exp_q[port].push_back(c);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (p_ack[port]) break;
        end
        check("ack_in_time", (k < 200), 1);
        @(posedge clk); #1;
        p_read[port]  = 1'b0;
        p_write[port] = 1'b0;
    endtask

    task automatic wait_quiet();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rd_q.size() == 0 && exp_q[0].size() == 0 && exp_q[1].size() == 0 && ready) break;
        end
        check("drain", (k < 300), 1);
    endtask

    task automatic init_dut(input int busy_cycles);
        int k;
        resetn = 1'b0; mem_busy = 1'b1;
        p_read = '0; p_write = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk);
            check("init_ready_low", ready, 0);
            check("init_quiet", {p_ack, p_rvalid, mem_rd, mem_wr, mem_refresh}, 0);
        end
        @(posedge clk); #1 mem_busy = 1'b0;
        for (k = 0; k < 2; k++) begin
            @(negedge clk);
            if (ready) break;
        end
        check("init_ready_high", ready, 1);
    endtask

    task automatic traffic(input int port, input int end_cyc);
        int op;
        while (cyc < end_cyc) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            op = $urandom_range(0, 3);
            do_req(port, (op == 0 || op == 1 || op == 3), (op >= 2),
                   addr_tbl[$urandom_range(0, 7)], DW'($urandom), BW'($urandom));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc, ref_before, wr_before;
        resetn = 1'b0; mem_busy = 1'b1;
        p_read = '0; p_write = '0; p_addr = '0; p_din = '0; p_wdm = '0;
        mem_dout = '0; mem_data_ready = 1'b0;
        rd_strobes = 0; ref_count = 0;

        init_dut(100);
        check("reset_rdata", rdata, 0);
        check("reset_total", total_written, 0);

        // single read returning 0xBEEF
        ref_mem[32'h12345] = 16'hBEEF;
        sdram[32'h12345]   = 16'hBEEF;
        do_req(0, 1'b1, 1'b0, 22'h12345, '0, '0);
        check("read_addr_held", mem_addr, 22'h12345);
        wait_quiet();
        check("read_strobes", rd_strobes, 1);
        check("read_rdata", rdata, 16'hBEEF);
        check("read_fail", fail, 0);

        // two ports writing continuously: grants alternate, 10 writes counted
        fork
            for (int i = 0; i < 5; i++) do_req(0, 1'b0, 1'b1, addr_tbl[i], DW'($urandom), BW'($urandom));
            for (int i = 0; i < 5; i++) do_req(1, 1'b0, 1'b1, addr_tbl[i+3], DW'($urandom), BW'($urandom));
        join
        wait_quiet();
        check("rr_total_written", total_written, 10);

        // read+write collision on port 1 serviced as a write
        do_req(1, 1'b1, 1'b1, addr_tbl[5], 16'hA5A5, 2'b01);
        check("collide_din", mem_din, 16'hA5A5);
        check("collide_wdm", mem_wdm, 2'b01);
        wait_quiet();
        check("collide_total", total_written, 11);
        do_req(0, 1'b1, 1'b0, addr_tbl[5], '0, '0);
        wait_quiet();

        // request withdrawn while controller busy: no ack, no command
        wr_before = model_written;
        fork
            do_req(0, 1'b1, 1'b0, addr_tbl[3], '0, '0);
            begin
                int k;
                for (k = 0; k < 50; k++) begin @(negedge clk); if (p_ack[0]) break; end
                @(posedge clk); #1;
                p_write[1] = 1'b1; p_addr[AW +: AW] = addr_tbl[4]; p_din[DW +: DW] = 16'h1234;
                repeat (2) @(posedge clk);
                #1 p_write[1] = 1'b0;
            end
        join
        wait_quiet();
        check("withdraw_no_write", total_written, 20'(wr_before));

        // random two-port traffic across several refresh periods
        start_cyc  = cyc;
        ref_before = ref_count;
        fork
            traffic(0, start_cyc + 3*RCYC + 40);
            traffic(1, start_cyc + 3*RCYC + 40);
        join
        wait_quiet();
        check_range("refresh_count", ref_count - ref_before, 3, 4);

        // read completing without mem_data_ready sets sticky fail
        drop_ready = 1'b1;
        do_req(0, 1'b1, 1'b0, addr_tbl[2], '0, '0);
        wait_quiet();
        drop_ready = 1'b0;
        check("fail_set", fail, 1);
        do_req(1, 1'b1, 1'b0, addr_tbl[1], '0, '0);
        wait_quiet();
        check("fail_sticky", fail, 1);

        // reset in the middle of a read abandons it
        do_req(0, 1'b1, 1'b0, addr_tbl[0], '0, '0);
        #3 resetn = 1'b0;
        #1;
        check("rst_outputs", {p_ack, p_rvalid, mem_rd, mem_wr, mem_refresh, ready, fail}, 0);
        check("rst_total", total_written, 0);
        check("rst_rdata", rdata, 0);
        init_dut(10);

        // normal operation after re-init
        do_req(1, 1'b0, 1'b1, addr_tbl[6], 16'h3C96, 2'b00);
        do_req(0, 1'b1, 1'b0, addr_tbl[6], '0, '0);
        wait_quiet();
        check("post_rst_total", total_written, 1);
        check("post_rst_rdata", rdata, 16'h3C96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
